fft_addr_sequencer: RTL and testbench

//  Control/address end of the in-place radix-2 FFT datapath. Walks every stage and

---
 rtl/fft_addr_sequencer.sv | 173 +++++++++++++++++
 tb/tb_fft_addr_sequencer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_addr_sequencer.sv
// fft_addr_sequencer
//   Address/control sequencer for an in-place radix-2 DIT FFT of N = 2**ADDR_SIZE
//   points. Issues one butterfly read per cycle, drains the butterfly pipe between
//   stages and regenerates the write enable by delaying the read strobe.
//   Optional feature macro: FFT_INVERSE_EN (adds i_inverse, conjugate twiddles).
//
//   state | meaning
//   IDLE  | waiting for i_start
//   RUN   | one butterfly read per cycle, k = 0..N/2-1 of stage s
//   DRAIN | PIPE_LATENCY cycles with no reads, waiting for write-back
//   DONE  | single-cycle completion pulse

module fft_addr_sequencer #(
  parameter int ADDR_SIZE    = 5,
  parameter int PIPE_LATENCY = 3
) (
  input  logic                         i_CLK,
  input  logic                         i_RST_N,
  input  logic                         i_start,
`ifdef FFT_INVERSE_EN
  input  logic                         i_inverse,
`endif
  output logic [ADDR_SIZE-1:0]         o_rdaddr_A,
  output logic [ADDR_SIZE-1:0]         o_rdaddr_B,
  output logic                         o_rd_en,
  output logic [ADDR_SIZE-1:0]         o_twiddle_idx,
  output logic [$clog2(ADDR_SIZE)-1:0] o_stage,
  output logic                         o_wr_en,
  output logic                         o_busy,
  output logic                         o_done
);

  localparam int AW = ADDR_SIZE;
  localparam int KW = ADDR_SIZE - 1;
  localparam int SW = $clog2(ADDR_SIZE);
  localparam int DW = $clog2(PIPE_LATENCY + 1);
  localparam logic [SW-1:0] S_LAST = SW'(ADDR_SIZE - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            r_state, w_state_nxt;
  logic [KW-1:0]     r_k, w_k_nxt;
  logic [SW-1:0]     r_s, w_s_nxt;
  logic [DW-1:0]     r_drain, w_drain_nxt;
  logic [PIPE_LATENCY-1:0] r_wr_pipe;

  logic [AW-1:0]     w_k_ext, w_sh, w_mask, w_low;
  logic [AW-1:0]     w_addr_a, w_addr_b, w_tw_fwd, w_tw;

  // State and counter registers
  always_ff @(posedge i_CLK) begin
    if (!i_RST_N) begin
      r_state <= IDLE;
      r_k     <= '0;
      r_s     <= '0;
      r_drain <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_k     <= w_k_nxt;
      r_s     <= w_s_nxt;
      r_drain <= w_drain_nxt;
    end
  end

  // Next-state logic; drain is a down-counter terminating at zero
  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_s_nxt     = r_s;
    w_drain_nxt = r_drain;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_state_nxt = RUN;
          w_k_nxt     = '0;
          w_s_nxt     = '0;
        end
      end
      RUN: begin
        if (&r_k) begin
          w_state_nxt = DRAIN;
          w_drain_nxt = DW'(PIPE_LATENCY - 1);
        end else begin
          w_k_nxt = r_k + KW'(1);
        end
      end
      DRAIN: begin
        if (r_drain == '0) begin
          if (r_s != S_LAST) begin
            w_state_nxt = RUN;
            w_s_nxt     = r_s + SW'(1);
            w_k_nxt     = '0;
          end else begin
            w_state_nxt = DONE;
          end
        end else begin
          w_drain_nxt = r_drain - DW'(1);
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Butterfly addresses and twiddle for the (s, k) about to be issued
  always_comb begin
    w_k_ext  = AW'(w_k_nxt);
    w_sh     = AW'(w_s_nxt);
    w_mask   = (AW'(1) << w_sh) - AW'(1);
    w_low    = w_k_ext & w_mask;
    w_addr_a = ((w_k_ext >> w_sh) << (w_sh + AW'(1))) | w_low;
    w_addr_b = w_addr_a | (AW'(1) << w_sh);
    w_tw_fwd = w_low << (AW'(AW - 1) - w_sh);
  end

`ifdef FFT_INVERSE_EN
  logic r_inverse;
  logic w_inv;

  // Direction is captured when a start is accepted and held for the whole run
  always_ff @(posedge i_CLK) begin
    if (!i_RST_N)
      r_inverse <= 1'b0;
    else if (r_state == IDLE && i_start)
      r_inverse <= i_inverse;
  end

  // The first read is issued on the accept edge, so bypass the latch in IDLE
  always_comb begin
    w_inv = (r_state == IDLE) ? i_inverse : r_inverse;
    w_tw  = w_inv ? (AW'(0) - w_tw_fwd) : w_tw_fwd;
  end
`else
  assign w_tw = w_tw_fwd;
`endif

  // Registered outputs; addresses hold while no read is issued
  always_ff @(posedge i_CLK) begin
    if (!i_RST_N) begin
      o_rd_en       <= 1'b0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_rdaddr_A    <= '0;
      o_rdaddr_B    <= '0;
      o_twiddle_idx <= '0;
      o_stage       <= '0;
    end else begin
      o_rd_en <= (w_state_nxt == RUN);
      o_busy  <= (w_state_nxt == RUN) || (w_state_nxt == DRAIN);
      o_done  <= (w_state_nxt == DONE);
      if (w_state_nxt == RUN) begin
        o_rdaddr_A    <= w_addr_a;
        o_rdaddr_B    <= w_addr_b;
        o_twiddle_idx <= w_tw;
        o_stage       <= w_s_nxt;
      end
    end
  end

  // Read strobe delayed by the pipe depth becomes the write enable
  always_ff @(posedge i_CLK) begin
    if (!i_RST_N) begin
      r_wr_pipe <= '0;
    end else begin
      r_wr_pipe[0] <= o_rd_en;
      for (int i = 1; i < PIPE_LATENCY; i++)
        r_wr_pipe[i] <= r_wr_pipe[i-1];
    end
  end

  assign o_wr_en = r_wr_pipe[PIPE_LATENCY-1];

endmodule

// File: tb/tb_fft_addr_sequencer.sv
// Testbench for fft_addr_sequencer (ADDR_SIZE=5, PIPE_LATENCY=3).
module tb_fft_addr_sequencer;

  localparam int ASZ    = 5;
  localparam int LAT    = 3;
  localparam int N      = 32;
  localparam int NH     = 16;
  localparam int P      = NH + LAT;
  localparam int RUNLEN = ASZ * P + 1;
  localparam int SW     = $clog2(ASZ);
  localparam int VW     = 4 + SW + 3 * ASZ;

  logic clk = 1'b0;
  logic i_RST_N;
  logic i_start;
`ifdef FFT_INVERSE_EN
  logic i_inverse = 1'b0;
`endif
  logic [ASZ-1:0] o_rdaddr_A, o_rdaddr_B, o_twiddle_idx;
  logic           o_rd_en, o_wr_en, o_busy, o_done;
  logic [SW-1:0]  o_stage;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fft_addr_sequencer #(.ADDR_SIZE(ASZ), .PIPE_LATENCY(LAT)) dut (
    .i_CLK         (clk),
    .i_RST_N       (i_RST_N),
    .i_start       (i_start),
`ifdef FFT_INVERSE_EN
    .i_inverse     (i_inverse),
`endif
    .o_rdaddr_A    (o_rdaddr_A),
    .o_rdaddr_B    (o_rdaddr_B),
    .o_rd_en       (o_rd_en),
    .o_twiddle_idx (o_twiddle_idx),
    .o_stage       (o_stage),
    .o_wr_en       (o_wr_en),
    .o_busy        (o_busy),
    .o_done        (o_done)
  );

  function automatic logic [VW-1:0] act_vec();
    return {o_rd_en, o_wr_en, o_busy, o_done, o_stage, o_rdaddr_A, o_rdaddr_B, o_twiddle_idx};
  endfunction

  // Expected outputs n cycles after start accept (n = 1..RUNLEN).
  function automatic logic [VW-1:0] exp_vec(input int n, input bit inv);
    int s, j, k, m, sp, lo, a, b, tw;
    bit rd, wr, busy, done;
    s = (n - 1) / P;
    j = (n - 1) % P;
    if (n > ASZ * P) begin
      s = ASZ - 1;
      j = NH - 1;
    end
    rd   = (n <= ASZ * P) && (j < NH);
    k    = (j < NH) ? j : NH - 1;
    m    = n - LAT;
    wr   = (m >= 1) && (m <= ASZ * P) && (((m - 1) % P) < NH);
    busy = (n >= 1) && (n <= ASZ * P);
    done = (n == ASZ * P + 1);
    sp   = 2 ** s;
    lo   = k % sp;
    a    = (k / sp) * 2 * sp + lo;
    b    = a + sp;
    tw   = lo * (2 ** (ASZ - 1 - s));
    if (inv) tw = (N - tw) % N;
    return {rd, wr, busy, done, SW'(s), ASZ'(a), ASZ'(b), ASZ'(tw)};
  endfunction

  task automatic test_reset();
    logic [VW-1:0] act;
    i_RST_N = 1'b0;
    i_start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      act = act_vec();
      n_checks++;
      if (act !== '0) begin
        n_fail++;
        $display("FAIL reset c=%0d got=%h exp=0", c, act);
      end
    end
    i_RST_N = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_full_run();
    logic [VW-1:0] act, ev;
    logic [31:0]   seen;
    int rd_cnt, wr_cnt;
    rd_cnt = 0;
    wr_cnt = 0;
    seen   = '0;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    for (int n = 1; n <= RUNLEN; n++) begin
      act = act_vec();
      ev  = exp_vec(n, 1'b0);
      n_checks++;
      if (act !== ev) begin
        n_fail++;
        $display("FAIL full_run n=%0d got=%h exp=%h", n, act, ev);
      end
      if (n == 1 || n == 21 || n == 92) begin
        n_checks++;
        if ({o_stage, o_rdaddr_A, o_rdaddr_B, o_twiddle_idx} !==
            ((n == 1)  ? {3'd0, 5'd0, 5'd1, 5'd0} :
             (n == 21) ? {3'd1, 5'd1, 5'd3, 5'd8} :
                         {3'd4, 5'd15, 5'd31, 5'd15})) begin
          n_fail++;
          $display("FAIL spot n=%0d got s=%0d A=%0d B=%0d idx=%0d", n, o_stage,
                   o_rdaddr_A, o_rdaddr_B, o_twiddle_idx);
        end
      end
      if (o_rd_en) begin
        rd_cnt++;
        seen = seen | (32'd1 << o_rdaddr_A) | (32'd1 << o_rdaddr_B);
      end
      if (o_wr_en) wr_cnt++;
      if (n <= ASZ * P && ((n - 1) % P) == NH - 1) begin
        n_checks++;
        if (seen !== 32'hFFFF_FFFF) begin
          n_fail++;
          $display("FAIL coverage stage=%0d got=%h exp=ffffffff", (n - 1) / P, seen);
        end
        seen = '0;
      end
      @(negedge clk);
    end
    n_checks++;
    if (rd_cnt != 80 || wr_cnt != 80) begin
      n_fail++;
      $display("FAIL pulse_count got rd=%0d wr=%0d exp 80/80", rd_cnt, wr_cnt);
    end
    n_checks++;
    if ({o_rd_en, o_wr_en, o_busy, o_done} !== 4'b0000) begin
      n_fail++;
      $display("FAIL post_idle got=%b exp=0000", {o_rd_en, o_wr_en, o_busy, o_done});
    end
  endtask

  task automatic test_start_ignored();
    logic [VW-1:0] act, ev;
`ifdef FFT_INVERSE_EN
    i_inverse = 1'b0;
`endif
    i_start = 1'b1;
    @(negedge clk);
    for (int n = 1; n <= RUNLEN; n++) begin
      act = act_vec();
      ev  = exp_vec(n, 1'b0);
      n_checks++;
      if (act !== ev) begin
        n_fail++;
        $display("FAIL start_ignored n=%0d got=%h exp=%h", n, act, ev);
      end
      i_start = (n < RUNLEN) ? 1'($urandom_range(0, 1)) : 1'b0;
`ifdef FFT_INVERSE_EN
      i_inverse = 1'($urandom_range(0, 1));
`endif
      @(negedge clk);
    end
`ifdef FFT_INVERSE_EN
    i_inverse = 1'b0;
`endif
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [VW-1:0] act, ev;
    i_start = 1'b1;
    @(negedge clk);
    for (int n = 1; n <= RUNLEN; n++) begin
      act = act_vec();
      ev  = exp_vec(n, 1'b0);
      n_checks++;
      if (act !== ev) begin
        n_fail++;
        $display("FAIL back_to_back n=%0d got=%h exp=%h", n, act, ev);
      end
      @(negedge clk);
    end
    n_checks++;
    if ({o_rd_en, o_busy, o_done} !== 3'b000) begin
      n_fail++;
      $display("FAIL b2b_idle got=%b exp=000", {o_rd_en, o_busy, o_done});
    end
    @(negedge clk);
    i_start = 1'b0;
    n_checks++;
    if ({o_rd_en, o_busy, o_stage, o_rdaddr_A, o_rdaddr_B, o_twiddle_idx} !==
        {1'b1, 1'b1, 3'd0, 5'd0, 5'd1, 5'd0}) begin
      n_fail++;
      $display("FAIL b2b_restart got rd=%b A=%0d B=%0d s=%0d", o_rd_en, o_rdaddr_A,
               o_rdaddr_B, o_stage);
    end
    i_RST_N = 1'b0;
    @(negedge clk);
    @(negedge clk);
    i_RST_N = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mid_reset();
    logic [VW-1:0] act, ev;
    int stop_n;
    stop_n = 2 * P + 1 + int'($urandom_range(0, NH - 1));
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    for (int n = 1; n < stop_n; n++) @(negedge clk);
    act = act_vec();
    ev  = exp_vec(stop_n, 1'b0);
    n_checks++;
    if (act !== ev) begin
      n_fail++;
      $display("FAIL pre_reset n=%0d got=%h exp=%h", stop_n, act, ev);
    end
    i_RST_N = 1'b0;
    @(negedge clk);
    i_RST_N = 1'b1;
    for (int c = 0; c < 5; c++) begin
      act = act_vec();
      n_checks++;
      if (act !== '0) begin
        n_fail++;
        $display("FAIL mid_reset c=%0d got=%h exp=0", c, act);
      end
      @(negedge clk);
    end
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    for (int n = 1; n <= RUNLEN; n++) begin
      act = act_vec();
      ev  = exp_vec(n, 1'b0);
      n_checks++;
      if (act !== ev) begin
        n_fail++;
        $display("FAIL restart n=%0d got=%h exp=%h", n, act, ev);
      end
      @(negedge clk);
    end
  endtask

`ifdef FFT_INVERSE_EN
  task automatic test_inverse();
    logic [VW-1:0] act, ev;
    i_inverse = 1'b1;
    i_start   = 1'b1;
    @(negedge clk);
    i_start   = 1'b0;
    i_inverse = 1'b0;
    for (int n = 1; n <= RUNLEN; n++) begin
      act = act_vec();
      ev  = exp_vec(n, 1'b1);
      n_checks++;
      if (act !== ev) begin
        n_fail++;
        $display("FAIL inverse n=%0d got=%h exp=%h", n, act, ev);
      end
      if (n == 1 || n == 4 * P + 4) begin
        n_checks++;
        if (o_twiddle_idx !== ((n == 1) ? 5'd0 : 5'd29)) begin
          n_fail++;
          $display("FAIL inverse_spot n=%0d got idx=%0d", n, o_twiddle_idx);
        end
      end
      @(negedge clk);
    end
  endtask
`endif

  initial begin
    i_RST_N = 1'b0;
    i_start = 1'b0;
    test_reset();
    test_full_run();
    test_start_ignored();
    test_back_to_back();
    test_mid_reset();
`ifdef FFT_INVERSE_EN
    test_inverse();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
